ro_multi_sensor_uart: RTL and testbench
=======================================

// Module: ro_multi_sensor_uart
// PURPOSE
//  Multi-channel successor to the single ring-oscillator thermal reporter. Counts rising edges of
//  N_CH divided ring-oscillator outputs over a fixed gate window in the clk domain, then reports
//  each channel's count as a 4-byte UART 8N1 frame on tx. Supports single-shot and continuous
//  modes, with count saturation and per-channel overflow flags.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency, Hz
//  BAUD        115_200      UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, >=4)
//  N_CH        4            number of oscillator channels, 1..16
//  CNT_W       16           count width per channel, 8..16
//  WINDOW_CYC  100_000      gate window length in clk cycles, >=16
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  ro_in      in   N_CH   divided ring-oscillator outputs, asynchronous to clk, each < clk/4
//  start      in   1      1-cycle request; begins a measurement from IDLE
//  mode_cont  in   1      1 = re-measure after each report; sampled at each report end
//  tx         out  1      UART serial output, idle high
//  busy       out  1      high in any state other than IDLE
//  done       out  1      1-cycle pulse after the last stop bit of a report
//  ovf        out  N_CH   sticky per-channel saturation flags for the last completed window
// BEHAVIOUR
//  Reset (async, rst_n=0): tx=1, busy=0, done=0, ovf=0, FSM=IDLE; all counters, sync flops
//   and shadow registers cleared. Reset mid-byte drives tx high immediately; no partial frame resumes.
//  Input sync: each ro_in bit passes through 2 flops; rising edge = sync[1] & ~sync_d. Edge
//   detection latency 3 clk cycles.
//  FSM: IDLE -> MEASURE -> LATCH -> SEND -> (MEASURE if mode_cont else IDLE).
//  IDLE: start=1 -> MEASURE next cycle; channel counters and window counter cleared on entry.
//   start in any other state is ignored (no queueing).
//  MEASURE: window counter runs 0..WINDOW_CYC-1; edges detected on those exact cycles are counted.
//   Counter saturates at 2^CNT_W-1; a further edge sets that channel's internal ovf bit.
//  LATCH (1 cycle): counts copied to shadow registers; ovf output updated from the internal
//   bits (replaces the previous window's flags); internal counters then cleared.
//  SEND: for ch = 0..N_CH-1 in order, transmit bytes 0xA5, ch[7:0], cnt[15:8], cnt[7:0]
//   (cnt zero-extended to 16 bits). Each byte: start bit 0, 8 data bits LSB first, stop bit 1,
//   each bit exactly CLKS_PER_BIT cycles. Bytes back-to-back: next start bit begins the cycle
//   after the previous stop bit ends. Report length = N_CH*4*10*CLKS_PER_BIT cycles.
//  First start bit drives tx on the first SEND cycle (1 cycle after LATCH).
//  Report end: done=1 for exactly one cycle on the cycle after the last stop bit; mode_cont
//   sampled on that same cycle. mode_cont=1 -> MEASURE (counters already clear, busy stays 1);
//   mode_cont=0 -> IDLE, busy=0 that cycle.
//  Edges arriving during LATCH/SEND are not counted (measure and send never overlap).
//  mode_cont changes during MEASURE/SEND have no effect until the report end.
// TESTING
//  Use CLK_HZ=100_000_000, BAUD=10_000_000 (10 clk/bit), N_CH=2, WINDOW_CYC=1000 unless stated.
//  T1 reset: hold rst_n=0 for 100 ns, release -> tx=1, busy=0, done=0, ovf=0; no tx edges in 2 us.
//  T2 single shot: ro_in[0] period 10 clk, ro_in[1]=0, start pulse -> bytes A5 00 00 64
//     (count 99..100 accepted) then A5 01 00 00; done pulses once; busy=0 after; ovf=0.
//  T3 saturation: CNT_W=8, ro_in[0] period 4 clk, WINDOW_CYC=2000 -> ch0 bytes A5 00 00 FF,
//     ovf[0]=1, ovf[1]=0.
//  T4 start while busy: extra start pulses in MEASURE and mid-SEND -> exactly one report (8 bytes),
//     one done pulse.
//  T5 continuous: mode_cont=1 + start -> 3 consecutive reports, each 1001+80*10 cycles apart
//     (1-cycle LATCH included); drop mode_cont during report 3 -> IDLE after it, done pulses=3.
//  T6 reset mid-frame: assert rst_n=0 during byte 2 of a report -> tx=1 same cycle; after release
//     no bytes emitted until a new start, next report is complete and correct.

Source files
------------

// File: rtl/ro_multi_sensor_uart.sv
// Ring-oscillator edge counters for N_CH channels, gated over a fixed window and
// reported over UART 8N1 as 4-byte frames per channel (A5, ch, cnt_hi, cnt_lo).

module ro_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             cnt_en,
    input  logic             clr,
    input  logic             latch,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);
    logic [1:0]       sync;
    logic             sync_d;
    logic [CNT_W-1:0] cnt;
    logic             ovf_int;
    logic             rise;

    assign rise = sync[1] & ~sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            sync_d  <= 1'b0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            shadow  <= '0;
            ovf     <= 1'b0;
        end else begin
            sync   <= {sync[0], ro};
            sync_d <= sync[1];
            if (latch) begin
                shadow  <= cnt;
                ovf     <= ovf_int;
                cnt     <= '0;
                ovf_int <= 1'b0;
            end else if (clr) begin
                cnt     <= '0;
                ovf_int <= 1'b0;
            end else if (cnt_en && rise) begin
                // saturate rather than wrap; the flag records the lost edges
                if (cnt == '1) ovf_int <= 1'b1;
                else           cnt     <= cnt + 1'b1;
            end
        end
    end
endmodule

module ro_multi_sensor_uart #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int N_CH       = 4,
    parameter int CNT_W      = 16,
    parameter int WINDOW_CYC = 100_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] ro_in,
    input  logic            start,
    input  logic            mode_cont,
    output logic            tx,
    output logic            busy,
    output logic            done,
    output logic [N_CH-1:0] ovf
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CPB_W = $clog2(CPB);
    localparam int WIN_W = $clog2(WINDOW_CYC);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CPB_W-1:0] CPB_LAST = CPB_W'(CPB - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, LATCH, SEND} state_t;
    state_t state, state_nx;

    logic [N_CH-1:0][CNT_W-1:0] shadow;
    logic [WIN_W-1:0] win_cnt;
    logic [CPB_W-1:0] clk_cnt;
    logic [3:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic [CH_W-1:0]  ch_idx;
    logic             bit_end, frame_end, rep_end;
    logic [15:0]      sel_cnt;
    logic [7:0]       cur_byte;
    logic [3:0]       data_pos;
    logic             frame_bit;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            ro_ch #(.CNT_W(CNT_W)) u_ch (
                .clk    (clk),
                .rst_n  (rst_n),
                .ro     (ro_in[g]),
                .cnt_en (state == MEASURE),
                .clr    (state == IDLE),
                .latch  (state == LATCH),
                .shadow (shadow[g]),
                .ovf    (ovf[g])
            );
        end
    endgenerate

    assign bit_end   = (clk_cnt == CPB_LAST);
    assign frame_end = bit_end && (bit_idx == 4'd9);
    assign rep_end   = frame_end && (byte_idx == 2'd3) && (ch_idx == CH_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = MEASURE;
            MEASURE: if (win_cnt == WIN_LAST) state_nx = LATCH;
            LATCH:   state_nx = SEND;
            SEND:    if (rep_end) state_nx = mode_cont ? MEASURE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            win_cnt  <= '0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            ch_idx   <= '0;
        end else begin
            state <= state_nx;
            done  <= (state == SEND) && rep_end;
            if (state == MEASURE && win_cnt != WIN_LAST) win_cnt <= win_cnt + 1'b1;
            else                                         win_cnt <= '0;
            if (state != SEND) begin
                clk_cnt  <= '0;
                bit_idx  <= '0;
                byte_idx <= '0;
                ch_idx   <= '0;
            end else if (!bit_end) begin
                clk_cnt <= clk_cnt + 1'b1;
            end else begin
                clk_cnt <= '0;
                if (bit_idx != 4'd9) begin
                    bit_idx <= bit_idx + 1'b1;
                end else begin
                    bit_idx  <= '0;
                    byte_idx <= byte_idx + 1'b1;
                    if (byte_idx == 2'd3)
                        ch_idx <= (ch_idx == CH_LAST) ? '0 : ch_idx + 1'b1;
                end
            end
        end
    end

    assign sel_cnt  = 16'(shadow[ch_idx]);
    assign data_pos = bit_idx - 4'd1;

    always_comb begin
        cur_byte = 8'hA5;
        case (byte_idx)
            2'd0: cur_byte = 8'hA5;
            2'd1: cur_byte = 8'(ch_idx);
            2'd2: cur_byte = sel_cnt[15:8];
            2'd3: cur_byte = sel_cnt[7:0];
            default: cur_byte = 8'hA5;
        endcase
    end

    always_comb begin
        frame_bit = 1'b1;
        if (bit_idx == 4'd0)      frame_bit = 1'b0;
        else if (bit_idx <= 4'd8) frame_bit = cur_byte[data_pos[2:0]];
    end

    // tx follows async-reset state directly so reset forces the line idle at once
    assign tx   = (state == SEND) ? frame_bit : 1'b1;
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_ro_multi_sensor_uart.sv
// Directed bench: UART decode of reports, single-shot, saturation, busy starts,
// continuous mode timing and mid-frame reset.

module tb_ro_multi_sensor_uart;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ro0 = 1'b0, ros0 = 1'b0;
    logic       ro0_en = 1'b0, ros_en = 1'b0;
    logic [1:0] ro_in, ro_s;
    logic       start = 1'b0, start_s = 1'b0;
    logic       mode_cont = 1'b0, mode_s = 1'b0;
    logic       tx, busy, done, tx_s, busy_s, done_s;
    logic [1:0] ovf, ovf_s;

    int n_err = 0, n_chk = 0;
    int cyc = 0, done_cnt = 0;
    int done_q[$];

    assign ro_in = {1'b0, ro0};
    assign ro_s  = {1'b0, ros0};

    ro_multi_sensor_uart #(.CLK_HZ(100_000_000), .BAUD(10_000_000), .N_CH(2),
                           .CNT_W(16), .WINDOW_CYC(1000)) dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .mode_cont(mode_cont),
        .tx(tx), .busy(busy), .done(done), .ovf(ovf));

    ro_multi_sensor_uart #(.CLK_HZ(100_000_000), .BAUD(10_000_000), .N_CH(2),
                           .CNT_W(8), .WINDOW_CYC(2000)) dut_s (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_s), .start(start_s), .mode_cont(mode_s),
        .tx(tx_s), .busy(busy_s), .done(done_s), .ovf(ovf_s));

    always #5 clk = ~clk;
    always #50 ro0  = ro0_en  ? ~ro0  : 1'b0;   // period 10 clk
    always #20 ros0 = ros_en ? ~ros0 : 1'b0;    // period 4 clk
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) begin done_cnt++; done_q.push_back(cyc); end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic txs(input bit sel);
        return sel ? tx_s : tx;
    endfunction

    task automatic pulse(input bit sel);
        @(negedge clk);
        if (sel) start_s = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start_s = 1'b0;
    endtask

    task automatic recv(input bit sel, input string tag, output logic [7:0] b);
        int n = 0;
        b = 'x;
        do begin @(negedge clk); n++; end while (txs(sel) && n < 4000);
        if (n >= 4000) begin chk({tag, "_timeout"}, 1, 0); return; end
        repeat (4) @(negedge clk);
        chk({tag, "_start"}, txs(sel), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = txs(sel);
        end
        repeat (10) @(negedge clk);
        chk({tag, "_stop"}, txs(sel), 1);
    endtask

    task automatic rep(input bit sel, input string tag, input int pulse_at);
        logic [7:0] exp [8];
        logic [7:0] b;
        string nm;
        exp = '{8'hA5, 8'h00, 8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h00};
        for (int k = 0; k < 8; k++) begin
            nm = $sformatf("%s_b%0d", tag, k);
            recv(sel, nm, b);
            if (k == 3 && !sel) chk(nm, (b == 8'h63 || b == 8'h64), 1);
            else                chk(nm, b, exp[k]);
            if (k == pulse_at) pulse(0);
        end
    endtask

    task automatic quiet(input bit sel, input int ncyc, input string tag);
        int lows = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (txs(sel) !== 1'b1) lows++;
        end
        chk(tag, lows, 0);
    endtask

    task automatic wait_done(input int target, input int lim, input string tag);
        int n = 0;
        while (done_cnt < target && n < lim) begin @(negedge clk); n++; end
        if (done_cnt < target) chk(tag, done_cnt, target);
    endtask

    initial begin
        int d0;
        logic [7:0] b;
        int lim;

        // T1 reset
        #100 rst_n = 1'b1;
        @(negedge clk);
        chk("t1_tx", tx, 1);
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        chk("t1_ovf", ovf, 0);
        quiet(0, 200, "t1_no_tx");

        // T2 single shot
        ro0_en = 1'b1;
        d0 = done_cnt;
        pulse(0);
        rep(0, "t2", -1);
        repeat (10) @(negedge clk);
        chk("t2_busy", busy, 0);
        chk("t2_ovf", ovf, 0);
        chk("t2_done", done_cnt - d0, 1);

        // T3 saturation on the 8-bit instance
        ros_en = 1'b1;
        pulse(1);
        rep(1, "t3", -1);
        repeat (10) @(negedge clk);
        chk("t3_ovf", ovf_s, 2'b01);
        chk("t3_busy", busy_s, 0);
        ros_en = 1'b0;

        // T4 start pulses while busy are ignored
        d0 = done_cnt;
        pulse(0);
        repeat (500) @(negedge clk);
        pulse(0);
        rep(0, "t4", 2);
        quiet(0, 3000, "t4_no_extra");
        chk("t4_done", done_cnt - d0, 1);

        // T5 continuous mode
        d0 = done_cnt;
        mode_cont = 1'b1;
        pulse(0);
        wait_done(d0 + 2, 5000, "t5_wait2");
        repeat (1101) @(negedge clk);
        mode_cont = 1'b0;
        wait_done(d0 + 3, 3000, "t5_wait3");
        repeat (5) @(negedge clk);
        chk("t5_busy", busy, 0);
        quiet(0, 3000, "t5_idle");
        chk("t5_done", done_cnt - d0, 3);
        if (done_q.size() >= d0 + 3) begin
            chk("t5_gap1", done_q[d0 + 1] - done_q[d0], 1801);
            chk("t5_gap2", done_q[d0 + 2] - done_q[d0 + 1], 1801);
        end else begin
            chk("t5_qlen", done_q.size(), d0 + 3);
        end

        // T6 reset during byte 2
        pulse(0);
        recv(0, "t6_pre0", b);
        chk("t6_pre0", b, 8'hA5);
        recv(0, "t6_pre1", b);
        chk("t6_pre1", b, 8'h00);
        lim = 0;
        do begin @(negedge clk); lim++; end while (tx && lim < 200);
        chk("t6_in_byte2", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", tx, 1);
        chk("t6_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet(0, 1500, "t6_quiet");
        d0 = done_cnt;
        pulse(0);
        rep(0, "t6", -1);
        repeat (10) @(negedge clk);
        chk("t6_done", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
